tom_busrsp: RTL and testbench

Internal-bus responder for Tom. It is the target end of the bus cycles that bus masters such as the CPU interface launch with `mreq`, `rw`, `w` and `justify`. The block decodes a fixed address window, inserts a fixed number of wait states, then returns a one-cycle `ack`. Behind the window sits a phrase-wide (64-bit) register bank. Writes are byte-lane masked and reads are steered onto the data bus.

---
 rtl/tom_bus_pkg.sv | 42 ++++
 rtl/tom_bus_lanes.sv | 42 ++++
 rtl/tom_busrsp.sv | 148 ++++++++++++++
 tb/tb_tom_busrsp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tom_bus_pkg.sv
// Shared Tom internal-bus definitions: transfer width codes, responder FSM states
// and the width/offset to byte-enable helpers.
package tom_bus_pkg;

  localparam logic [3:0] W_BYTE   = 4'h1;
  localparam logic [3:0] W_WORD   = 4'h2;
  localparam logic [3:0] W_LONG   = 4'h4;
  localparam logic [3:0] W_PHRASE = 4'h8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } rsp_state_t;

  function automatic logic width_ok(input logic [3:0] w);
    return (w == W_BYTE) || (w == W_WORD) || (w == W_LONG) || (w == W_PHRASE);
  endfunction

  // Offset aligned down to the transfer size; illegal widths collapse to 0.
  function automatic logic [2:0] align_off(input logic [3:0] w, input logic [2:0] off);
    case (w)
      W_BYTE:  return off;
      W_WORD:  return {off[2:1], 1'b0};
      W_LONG:  return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] byte_enables(input logic [3:0] w, input logic [2:0] off);
    logic [2:0] o;
    o = align_off(w, off);
    case (w)
      W_BYTE:   return 8'h01 << o;
      W_WORD:   return 8'h03 << o;
      W_LONG:   return 8'h0F << o;
      W_PHRASE: return 8'hFF;
      default:  return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/tom_bus_lanes.sv
// Combinational lane steerer: RD=0 aligns write data onto lanes, RD=1 justifies read data.
// The justification shifters exist only with TOM_BUSRSP_JUSTIFY_EN defined.
module tom_bus_lanes #(
  parameter bit RD = 1'b0
) (
  input  logic [63:0] data,
  input  logic [2:0]  off,
  input  logic [7:0]  be,
  input  logic        justify,
  output logic [63:0] q
);

  logic [63:0] lane_mask;

  always_comb begin
    lane_mask = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      lane_mask[8*k +: 8] = {8{be[k]}};
    end
  end

`ifdef TOM_BUSRSP_JUSTIFY_EN
  logic [5:0] sh;
  assign sh = {off, 3'b000};

  generate
    if (RD) begin : g_rd
      // Mask first so only the enabled lanes land in the low bytes.
      assign q = justify ? ((data & lane_mask) >> sh) : (data & lane_mask);
    end else begin : g_wr
      assign q = (justify ? (data << sh) : data) & lane_mask;
    end
  endgenerate
`else
  // Lane-placed data is the same masking in both directions.
  localparam bit unused_rd = RD;
  logic unused_steer;
  assign unused_steer = ^{off, justify};
  assign q = data & lane_mask;
`endif

endmodule

// File: rtl/tom_busrsp.sv
// Tom internal-bus responder: window decode, wait-state FSM, 64-bit byte-masked bank.
// Justified transfers are honoured only when TOM_BUSRSP_JUSTIFY_EN is defined.
module tom_busrsp
  import tom_bus_pkg::*;
#(
  parameter logic [23:0] BASE        = 24'hF1C000,
  parameter int unsigned AW          = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_0,
  input  logic        reset,
  input  logic        mreq,
  input  logic [23:0] a,
  input  logic        rw,
  input  logic [3:0]  w,
  input  logic        justify,
  input  logic [63:0] din,
  output logic        ack,
  output logic [63:0] dout,
  output logic        dout_oe,
  output logic        err
);

  localparam int unsigned NPH     = 1 << AW;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  rsp_state_t     state, state_d;
  logic [3:0]     cnt, cnt_d;
  logic           hit, accept;
  logic [AW-1:0]  a_idx, cap_idx;
  logic [2:0]     a_off, cap_off;
  logic [7:0]     a_be, cap_be;
  logic           cap_rw, cap_justify;
  logic [63:0]    cap_din, cap_rdata;
  logic [63:0]    wr_aligned, rd_phrase, rd_steered;
  logic [63:0]    bank [NPH];

  assign hit    = mreq && (a[23:3+AW] == BASE[23:3+AW]);
  assign accept = hit && (state != WAIT);
  assign a_idx  = a[3+AW-1:3];
  assign a_off  = align_off(w, a[2:0]);
  assign a_be   = byte_enables(w, a[2:0]);
  assign ack    = (state == ACK);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE, ACK: begin
        if (hit) begin
          if (WAIT_STATES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = ACK;
        else           cnt_d   = cnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk_0) begin
    if (accept) begin
      cap_idx     <= a_idx;
      cap_off     <= a_off;
      cap_be      <= a_be;
      cap_rw      <= rw;
      cap_justify <= justify;
      cap_din     <= din;
      cap_rdata   <= rd_steered;
    end
  end

  tom_bus_lanes #(.RD(1'b0)) u_wr_lanes (
    .data    (cap_din),
    .off     (cap_off),
    .be      (cap_be),
    .justify (cap_justify),
    .q       (wr_aligned)
  );

  tom_bus_lanes #(.RD(1'b1)) u_rd_lanes (
    .data    (rd_phrase),
    .off     (a_off),
    .be      (a_be),
    .justify (justify),
    .q       (rd_steered)
  );

  // A read captured on a write's ACK edge sees the lanes that edge is writing.
  always_comb begin
    rd_phrase = bank[a_idx];
    if (state == ACK && !cap_rw && cap_idx == a_idx) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (cap_be[k]) rd_phrase[8*k +: 8] = wr_aligned[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_0) begin
    if (!reset && state == ACK && !cap_rw) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (cap_be[k]) bank[cap_idx][8*k +: 8] <= wr_aligned[8*k +: 8];
      end
    end
  end

  // With no wait states the access enters ACK on its capture edge, so data comes from the inputs.
  always_ff @(posedge clk_0) begin
    if (reset) begin
      dout    <= '0;
      dout_oe <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (state_d == ACK) begin
        if (accept) begin
          dout    <= rw ? rd_steered : '0;
          dout_oe <= rw;
        end else begin
          dout    <= cap_rw ? cap_rdata : '0;
          dout_oe <= cap_rw;
        end
      end else begin
        dout    <= '0;
        dout_oe <= 1'b0;
      end
      if ((hit && state == WAIT) || (accept && !width_ok(w))) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tom_busrsp.sv
// Self-checking bench for tom_busrsp: directed steps plus random traffic against a byte-array model.
module tb_tom_busrsp;

  localparam logic [23:0] BASE = 24'hF1C000;
  localparam int unsigned AW   = 4;
  localparam int unsigned WS   = 1;
  localparam int unsigned NB   = 8 * (1 << AW);

  logic        clk_0   = 1'b0;
  logic        reset   = 1'b1;
  logic        mreq    = 1'b0;
  logic [23:0] a       = '0;
  logic        rw      = 1'b0;
  logic [3:0]  w       = 4'h8;
  logic        justify = 1'b0;
  logic [63:0] din     = '0;
  logic        ack, dout_oe, err;
  logic [63:0] dout;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  mem [NB];
  logic        model_err = 1'b0;

  always #5 clk_0 = ~clk_0;

  tom_busrsp #(.BASE(BASE), .AW(AW), .WAIT_STATES(WS)) dut (
    .clk_0   (clk_0),
    .reset   (reset),
    .mreq    (mreq),
    .a       (a),
    .rw      (rw),
    .w       (w),
    .justify (justify),
    .din     (din),
    .ack     (ack),
    .dout    (dout),
    .dout_oe (dout_oe),
    .err     (err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_0);
    #1;
  endtask

  task automatic drive(input logic [23:0] ad, input logic r, input logic [3:0] wd,
                       input logic j, input logic [63:0] d);
    mreq = 1'b1; a = ad; rw = r; w = wd; justify = j; din = d;
  endtask

  task automatic idle_bus();
    mreq = 1'b0; a = 24'($urandom); rw = 1'($urandom); w = 4'($urandom);
    justify = 1'($urandom); din = {$urandom, $urandom};
  endtask

  function automatic int unsigned size_of(input logic [3:0] wd);
    case (wd)
      4'h1: return 1;
      4'h2: return 2;
      4'h4: return 4;
      4'h8: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic eff_j(input logic j);
`ifdef TOM_BUSRSP_JUSTIFY_EN
    return j;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned start_lane(input logic [23:0] ad, input int unsigned sz);
    int unsigned ofs;
    ofs = ad[2:0];
    return (sz == 0) ? 0 : (ofs / sz) * sz;
  endfunction

  function automatic int unsigned phrase_base(input logic [23:0] ad);
    int unsigned wb;
    wb = ad[3+AW-1:0];
    return wb - (wb % 8);
  endfunction

  task automatic model_write(input logic [23:0] ad, input logic [3:0] wd, input logic j, input logic [63:0] d);
    int unsigned sz, o, pb, lane;
    sz = size_of(wd); o = start_lane(ad, sz); pb = phrase_base(ad);
    for (int unsigned i = 0; i < sz; i++) begin
      lane = o + i;
      mem[pb + lane] = eff_j(j) ? d[8*i +: 8] : d[8*lane +: 8];
    end
  endtask

  function automatic logic [63:0] model_read(input logic [23:0] ad, input logic [3:0] wd, input logic j);
    int unsigned sz, o, pb, lane;
    logic [63:0] r;
    r = '0; sz = size_of(wd); o = start_lane(ad, sz); pb = phrase_base(ad);
    for (int unsigned i = 0; i < sz; i++) begin
      lane = o + i;
      if (eff_j(j)) r[8*i +: 8] = mem[pb + lane];
      else          r[8*lane +: 8] = mem[pb + lane];
    end
    return r;
  endfunction

  task automatic xact(input logic [23:0] ad, input logic r, input logic [3:0] wd,
                      input logic j, input logic [63:0] d, input string tag);
    logic [63:0] exp;
    int unsigned k;
    exp = r ? model_read(ad, wd, j) : 64'h0;
    if (size_of(wd) == 0) model_err = 1'b1;
    drive(ad, r, wd, j, d);
    cycle();
    idle_bus();
    k = 0;
    while (ack !== 1'b1 && k < 20) begin cycle(); k++; end
    chk($sformatf("%s.latency", tag), 64'(k), 64'(WS));
    chk($sformatf("%s.dout", tag), dout, exp);
    chk($sformatf("%s.dout_oe", tag), 64'(dout_oe), 64'(r));
    if (!r) model_write(ad, wd, j, d);
    cycle();
    chk($sformatf("%s.ack_drop", tag), 64'(ack), 64'h0);
    chk($sformatf("%s.dout_idle", tag), dout, 64'h0);
    chk($sformatf("%s.err", tag), 64'(err), 64'(model_err));
  endtask

  task automatic b2b(input logic [23:0] a0, input logic r0, input logic [3:0] w0, input logic j0, input logic [63:0] d0,
                     input logic [23:0] a1, input logic r1, input logic [3:0] w1, input logic j1, input logic [63:0] d1,
                     input string tag);
    logic [63:0] exp;
    int unsigned k;
    exp = r0 ? model_read(a0, w0, j0) : 64'h0;
    drive(a0, r0, w0, j0, d0);
    cycle();
    idle_bus();
    k = 0;
    while (ack !== 1'b1 && k < 20) begin cycle(); k++; end
    chk($sformatf("%s.first_latency", tag), 64'(k), 64'(WS));
    chk($sformatf("%s.first_dout", tag), dout, exp);
    if (!r0) model_write(a0, w0, j0, d0);
    exp = r1 ? model_read(a1, w1, j1) : 64'h0;
    drive(a1, r1, w1, j1, d1);
    cycle();
    idle_bus();
    k = 1;
    while (ack !== 1'b1 && k < 20) begin cycle(); k++; end
    chk($sformatf("%s.ack_gap", tag), 64'(k), 64'(WS + 1));
    chk($sformatf("%s.second_dout", tag), dout, exp);
    chk($sformatf("%s.second_oe", tag), 64'(dout_oe), 64'(r1));
    if (!r1) model_write(a1, w1, j1, d1);
    cycle();
    chk($sformatf("%s.ack_drop", tag), 64'(ack), 64'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_bus();
    repeat (2) cycle();
    reset = 1'b0;
    model_err = 1'b0;
  endtask

  function automatic logic [23:0] rand_addr();
    return BASE + 24'($urandom_range(0, NB - 1));
  endfunction

  function automatic logic [3:0] rand_width();
    return 4'(1 << $urandom_range(0, 3));
  endfunction

  initial begin
    logic [63:0] keep;

    // Reset values
    do_reset();
    chk("reset.ack", 64'(ack), 64'h0);
    chk("reset.dout", dout, 64'h0);
    chk("reset.dout_oe", 64'(dout_oe), 64'h0);
    chk("reset.err", 64'(err), 64'h0);

    // Fill the whole bank so every later read has known contents
    for (int unsigned i = 0; i < (1 << AW); i++)
      xact(BASE + 24'(8 * i), 1'b0, 4'h8, 1'b0, {$urandom, $urandom}, $sformatf("init%0d", i));

    // Phrase write then read
    xact(24'hF1C008, 1'b0, 4'h8, 1'b0, 64'h0123456789ABCDEF, "ph_wr");
    xact(24'hF1C008, 1'b1, 4'h8, 1'b0, 64'h0, "ph_rd");

    // Justified byte into a zeroed phrase
    xact(24'hF1C008, 1'b0, 4'h8, 1'b0, 64'h0, "zero_ph");
    xact(24'hF1C00B, 1'b0, 4'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFA5, "jb_wr");
    xact(24'hF1C008, 1'b1, 4'h8, 1'b0, 64'h0, "jb_ph_rd");
    xact(24'hF1C00B, 1'b1, 4'h1, 1'b1, 64'h0, "jb_rd");

    // Back-to-back write then read of the same phrase
    b2b(24'hF1C010, 1'b0, 4'h8, 1'b0, 64'hDEADBEEF_CAFEF00D,
        24'hF1C010, 1'b1, 4'h8, 1'b0, 64'h0, "b2b_wr_rd");
    b2b(24'hF1C016, 1'b0, 4'h2, 1'b0, 64'h5A5A_1234_0000_0000,
        24'hF1C014, 1'b1, 4'h4, 1'b0, 64'h0, "b2b_word_long");

    // Random traffic
    for (int unsigned i = 0; i < 60; i++)
      xact(rand_addr(), 1'($urandom), rand_width(), 1'($urandom), {$urandom, $urandom},
           $sformatf("rnd%0d", i));
    for (int unsigned i = 0; i < 15; i++) begin
      logic [23:0] ad;
      ad = rand_addr();
      b2b(ad, 1'b0, rand_width(), 1'($urandom), {$urandom, $urandom},
          (($urandom & 1) != 0) ? ad : rand_addr(), 1'b1, rand_width(), 1'($urandom), 64'h0,
          $sformatf("rb2b%0d", i));
    end

    // Miss outside the window
    drive(24'hF1D000, 1'b1, 4'h8, 1'b0, 64'h0);
    cycle();
    idle_bus();
    for (int unsigned i = 0; i < 4; i++) begin
      chk($sformatf("miss.no_ack%0d", i), 64'(ack), 64'h0);
      cycle();
    end
    chk("miss.err", 64'(err), 64'h0);

    // Illegal width: acks, reads zero, sets sticky err
    xact(BASE + 24'h20, 1'b1, 4'h3, 1'b0, 64'h0, "badw_rd");
    xact(BASE + 24'h28, 1'b0, 4'h3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "badw_wr");
    xact(BASE + 24'h28, 1'b1, 4'h8, 1'b0, 64'h0, "badw_check");

    // Hit during WAIT is dropped
    do_reset();
    chk("wait_hit.err_cleared", 64'(err), 64'h0);
    drive(BASE + 24'h10, 1'b0, 4'h8, 1'b0, 64'h1111_2222_3333_4444);
    cycle();
    drive(BASE + 24'h10, 1'b0, 4'h8, 1'b0, 64'h9999_8888_7777_6666);
    cycle();
    idle_bus();
    chk("wait_hit.ack", 64'(ack), 64'h1);
    model_write(BASE + 24'h10, 4'h8, 1'b0, 64'h1111_2222_3333_4444);
    model_err = 1'b1;
    cycle();
    chk("wait_hit.single_ack", 64'(ack), 64'h0);
    chk("wait_hit.err", 64'(err), 64'h1);
    xact(BASE + 24'h10, 1'b1, 4'h8, 1'b0, 64'h0, "wait_hit.rd");

    // Reset mid-access discards the pending write
    do_reset();
    keep = model_read(BASE + 24'h18, 4'h8, 1'b0);
    drive(BASE + 24'h18, 1'b0, 4'h8, 1'b0, ~keep);
    cycle();
    idle_bus();
    reset = 1'b1;
    cycle();
    chk("rst_mid.ack0", 64'(ack), 64'h0);
    reset = 1'b0;
    cycle();
    chk("rst_mid.ack1", 64'(ack), 64'h0);
    chk("rst_mid.err", 64'(err), 64'h0);
    xact(BASE + 24'h18, 1'b1, 4'h8, 1'b0, 64'h0, "rst_mid.rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
